// File: rtl/exp_sigma_scheduler_pkg.sv
// Shared types and widths for the exp-sigma engine scheduler.
package exp_sigma_scheduler_pkg;

    localparam int unsigned SigmaW = 18;
    localparam int unsigned DataW  = 17;
    localparam int unsigned AddrW  = 6;
    localparam int unsigned CntW   = 6;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StRun,
        StGap
    } state_e;

endpackage

// File: rtl/exp_sigma_scheduler_if.sv
// Requester and engine side signals of the exp-sigma scheduler.
interface exp_sigma_scheduler_if #(
    parameter int unsigned NReq = 4,
    parameter int unsigned TagW = 2
);
    import exp_sigma_scheduler_pkg::*;

    logic [NReq-1:0]        req;
    logic [NReq*SigmaW-1:0] sigma;
    logic [NReq-1:0]        ack;
    logic                   err;
    logic                   busy;
    logic                   eng_start;
    logic [SigmaW-1:0]      eng_sigma;
    logic [DataW-1:0]       eng_data;
    logic [AddrW-1:0]       eng_addr;
    logic                   eng_valid;
    logic                   eng_done;
    logic [DataW-1:0]       data;
    logic [AddrW-1:0]       addr;
    logic [TagW-1:0]        tag;
    logic                   valid;

    modport master (
        output req, sigma, eng_data, eng_addr, eng_valid, eng_done,
        input  ack, err, busy, eng_start, eng_sigma, data, addr, tag, valid
    );

    modport slave (
        input  req, sigma, eng_data, eng_addr, eng_valid, eng_done,
        output ack, err, busy, eng_start, eng_sigma, data, addr, tag, valid
    );

endinterface

// File: rtl/exp_sigma_scheduler_rr_arbiter.sv
// Round-robin pick: first set request at or above the pointer, wrapping around.
module exp_sigma_scheduler_rr_arbiter #(
    parameter int unsigned NReq = 4,
    parameter int unsigned TagW = 2
) (
    input  logic [NReq-1:0] req,
    input  logic [TagW-1:0] ptr,
    output logic [NReq-1:0] gnt,
    output logic [TagW-1:0] gnt_idx,
    output logic            gnt_any
);

    always_comb begin
        int unsigned k;
        logic [TagW-1:0] kk;
        k       = 0;
        kk      = '0;
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int unsigned i = 0; i < NReq; i++) begin
            k  = (32'(ptr) + i) % NReq;
            kk = TagW'(k);
            if (!gnt_any && req[kk]) begin
                gnt_any  = 1'b1;
                gnt[kk]  = 1'b1;
                gnt_idx  = kk;
            end
        end
    end

endmodule

// File: rtl/exp_sigma_scheduler.sv
// Shares one exp(x*sigma) engine between requesters: round-robin grant, start pulse,
// tagged result forwarding, sample-count and timeout checking.
module exp_sigma_scheduler
    import exp_sigma_scheduler_pkg::*;
#(
    parameter int unsigned NReq    = 4,
    parameter int unsigned TagW    = 2,
    parameter int unsigned NPoints = 53,
    parameter int unsigned GapCyc  = 4,
    parameter int unsigned Timeout = 128
) (
    input logic                  clk,
    input logic                  rst,
    exp_sigma_scheduler_if.slave bus
);

    localparam int unsigned TmoW  = $clog2(Timeout + 1);
    localparam int unsigned GapW  = $clog2(GapCyc + 1);
    localparam int unsigned CntW1 = CntW + 1;

    state_e state_q, state_d;

    logic [TagW-1:0]   owner_q;
    logic [NReq-1:0]   owner_oh_q;
    logic [TagW-1:0]   ptr_q;
    logic [SigmaW-1:0] sigma_q;
    logic [CntW-1:0]   sample_q;
    logic [TmoW-1:0]   tmo_q;
    logic [GapW-1:0]   gap_q;
    logic [DataW-1:0]  data_q;
    logic [AddrW-1:0]  addr_q;
    logic [TagW-1:0]   tag_q;
    logic              valid_q;

    logic [NReq-1:0] gnt;
    logic [TagW-1:0] gnt_idx;
    logic            gnt_any;

    logic [CntW:0]   sample_sum;
    logic [CntW-1:0] sample_sat;
    logic            done_hit;
    logic            tmo_hit;
    logic            job_end;
    logic            run_valid;

    exp_sigma_scheduler_rr_arbiter #(
        .NReq (NReq),
        .TagW (TagW)
    ) u_arb (
        .req     (bus.req),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    // Sample count including a valid arriving in the same cycle as done.
    assign sample_sum = {1'b0, sample_q} + {{CntW{1'b0}}, bus.eng_valid};
    assign sample_sat = sample_sum[CntW] ? '1 : sample_sum[CntW-1:0];
    assign done_hit   = (state_q == StRun) && bus.eng_done;
    assign tmo_hit    = (state_q == StRun) && (tmo_q == TmoW'(Timeout - 1));
    assign job_end    = done_hit || tmo_hit;
    assign run_valid  = (state_q == StRun) && bus.eng_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (gnt_any) state_d = StStart;
            StStart: state_d = StRun;
            StRun:   if (job_end) state_d = StGap;
            StGap:   if (gap_q == GapW'(GapCyc - 1)) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.eng_start = (state_q == StStart);
        bus.busy      = (state_q != StIdle);
        bus.ack       = job_end ? owner_oh_q : '0;
        // Timeout always fails; done fails only on a wrong point count.
        bus.err       = job_end && (!done_hit || (sample_sum != CntW1'(NPoints)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q    <= '0;
            owner_oh_q <= '0;
            ptr_q      <= '0;
            sigma_q    <= '0;
            sample_q   <= '0;
            tmo_q      <= '0;
            gap_q      <= '0;
            data_q     <= '0;
            addr_q     <= '0;
            tag_q      <= '0;
            valid_q    <= 1'b0;
        end else begin
            if ((state_q == StIdle) && gnt_any) begin
                owner_q    <= gnt_idx;
                owner_oh_q <= gnt;
                sigma_q    <= bus.sigma[gnt_idx*SigmaW +: SigmaW];
            end
            if (state_q == StStart) begin
                sample_q <= '0;
                tmo_q    <= '0;
            end
            if (state_q == StRun) begin
                tmo_q <= tmo_q + TmoW'(1);
                if (bus.eng_valid) sample_q <= sample_sat;
            end
            gap_q   <= (state_q == StGap) ? gap_q + GapW'(1) : '0;
            valid_q <= run_valid;
            if (run_valid) begin
                data_q <= bus.eng_data;
                addr_q <= bus.eng_addr;
                tag_q  <= owner_q;
            end
            if (job_end) begin
                ptr_q <= (owner_q == TagW'(NReq - 1)) ? '0 : owner_q + TagW'(1);
            end
        end
    end

    assign bus.eng_sigma = sigma_q;
    assign bus.data      = data_q;
    assign bus.addr      = addr_q;
    assign bus.tag       = tag_q;
    assign bus.valid     = valid_q;

endmodule

// File: tb/tb_exp_sigma_scheduler.sv
// Randomized bench for exp_sigma_scheduler with a behavioural engine and scoreboard.
module tb_exp_sigma_scheduler;

    localparam int unsigned NPoints = 53;
    localparam int unsigned GapCyc  = 4;
    localparam int unsigned Timeout = 128;

    logic clk = 1'b0;
    logic rst;

    exp_sigma_scheduler_if #(.NReq(4), .TagW(2)) bus ();

    exp_sigma_scheduler #(
        .NReq    (4),
        .TagW    (2),
        .NPoints (NPoints),
        .GapCyc  (GapCyc),
        .Timeout (Timeout)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_pass   = 0;
    int n_checks = 0;
    int cyc      = 0;
    int last_ack = -1000;
    int last_start = 0;
    bit prev_start = 1'b0;
    int rr_ptr   = 0;

    logic [24:0] vq[$];
    logic [3:0]  ack_q[$];
    logic        err_q[$];
    int          ack_cyc_q[$];
    logic [17:0] sigma_slot[4];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Requester closest at or after the pointer, going upward with wrap.
    function automatic int predict(input logic [3:0] mask, input int ptr);
        int best, bestd, d;
        best  = -1;
        bestd = 99;
        for (int k = 0; k < 4; k++) begin
            d = (k - ptr + 4) % 4;
            if (mask[k] && d < bestd) begin
                best  = k;
                bestd = d;
            end
        end
        return best;
    endfunction

    task automatic set_sigmas(input bit first_fixed);
        for (int k = 0; k < 4; k++) begin
            sigma_slot[k] = 18'($urandom);
            if (first_fixed && k == 0) sigma_slot[k] = 18'h10000;
            bus.sigma[k*18 +: 18] = sigma_slot[k];
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        rr_ptr = 0;
    endtask

    task automatic wait_start(output bit got);
        got = 1'b0;
        for (int w = 0; w < 300 && !got; w++) begin
            @(posedge clk);
            #1 got = bus.eng_start;
        end
    endtask

    task automatic run_job(input int owner, input int nval, input bit coincide,
                           input bit hang, input bit drop);
        bit got;
        int a0, bad;
        logic [16:0] d;
        logic [5:0]  a;
        logic [24:0] exp_q[$];
        vq.delete();
        a0 = ack_q.size();
        wait_start(got);
        check_eq("start_seen", got, 1);
        if (!got) return;
        check_eq("eng_sigma", bus.eng_sigma, sigma_slot[owner]);
        check_eq("busy_run", bus.busy, 1);
        if (!hang) begin
            for (int i = 0; i < nval; i++) begin
                @(posedge clk);
                #1;
                d = 17'($urandom);
                a = 6'(i - 26);
                bus.eng_valid = 1'b1;
                bus.eng_data  = d;
                bus.eng_addr  = a;
                bus.eng_done  = coincide && (i == nval - 1);
                exp_q.push_back({2'(owner), d, a});
            end
            if (!coincide || nval == 0) begin
                @(posedge clk);
                #1;
                bus.eng_valid = 1'b0;
                bus.eng_done  = 1'b1;
            end
            @(posedge clk);
            #1;
            bus.eng_valid = 1'b0;
            bus.eng_done  = 1'b0;
        end
        got = 1'b0;
        for (int w = 0; w < Timeout + 50 && !got; w++) begin
            if (ack_q.size() > a0) got = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        check_eq("ack_seen", got, 1);
        if (drop) bus.req[owner] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        if (got) begin
            check_eq("ack_vec", ack_q[a0], 32'(1) << owner);
            check_eq("err", err_q[a0], (hang || nval != NPoints) ? 1 : 0);
            if (hang) check_eq("tmo_cycle", ack_cyc_q[a0] - last_start, Timeout);
        end
        check_eq("n_valid", vq.size(), exp_q.size());
        bad = 0;
        for (int i = 0; i < vq.size() && i < exp_q.size(); i++) if (vq[i] !== exp_q[i]) bad++;
        check_eq("stream", bad, 0);
        rr_ptr = (owner + 1) % 4;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.valid) vq.push_back({bus.tag, bus.data, bus.addr});
            if (bus.ack != 0) begin
                ack_q.push_back(bus.ack);
                err_q.push_back(bus.err);
                ack_cyc_q.push_back(cyc);
                last_ack = cyc;
            end
            if (bus.eng_start) begin
                check_eq("start_pulse", prev_start, 0);
                check_eq("start_gap", (cyc - last_ack > GapCyc) ? 1 : 0, 1);
                last_start = cyc;
            end
            prev_start = bus.eng_start;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int o, m, nv;
        bit co, got, ok;
        int a0;
        rst = 1'b1;
        bus.req = '0;
        bus.sigma = '0;
        bus.eng_data = '0;
        bus.eng_addr = '0;
        bus.eng_valid = 1'b0;
        bus.eng_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ctrl", {bus.ack, bus.err, bus.busy, bus.eng_start, bus.valid, bus.tag}, 0);
        check_eq("rst_data", {bus.eng_sigma, bus.data, bus.addr}, 0);
        rst = 1'b0;

        // Single requester, fixed sigma
        set_sigmas(1);
        bus.req = 4'b0001;
        run_job(0, NPoints, 0, 0, 1);

        // All four at once from pointer 0
        do_reset();
        set_sigmas(0);
        bus.req = 4'b1111;
        for (int j = 0; j < 4; j++) begin
            o = predict(bus.req, rr_ptr);
            check_eq("order_all", o, j);
            run_job(o, NPoints, 1'($urandom_range(0, 1)), 0, 1);
        end

        // Two requesters held high continuously
        set_sigmas(0);
        bus.req = 4'b0101;
        for (int j = 0; j < 4; j++) begin
            o = predict(bus.req, rr_ptr);
            run_job(o, NPoints, 0, 0, j == 3);
        end
        bus.req = '0;

        // Short count, then full count with done on the last sample
        set_sigmas(0);
        bus.req = 4'b0010;
        run_job(1, 52, 0, 0, 1);
        bus.req = 4'b0010;
        run_job(1, NPoints, 1, 0, 1);

        // Engine hangs, then the other requester is served
        bus.req = 4'b1001;
        o = predict(bus.req, rr_ptr);
        run_job(o, 0, 0, 1, 1);
        o = predict(bus.req, rr_ptr);
        run_job(o, NPoints, 0, 0, 1);

        // Random request sets and engine behaviour
        repeat (4) begin
            set_sigmas(0);
            bus.req = 4'($urandom_range(1, 15));
            while (bus.req != 0) begin
                o  = predict(bus.req, rr_ptr);
                m  = $urandom_range(0, 2);
                nv = (m == 2) ? $urandom_range(45, 52) : NPoints;
                co = (m == 1) ? 1'b1 : ((m == 2) ? 1'($urandom_range(0, 1)) : 1'b0);
                run_job(o, nv, co, 0, 1);
            end
        end

        // Reset in the middle of a job
        set_sigmas(0);
        bus.req = 4'b0100;
        a0 = ack_q.size();
        wait_start(got);
        check_eq("start_seen_rst", got, 1);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            bus.eng_valid = 1'b1;
            bus.eng_data  = 17'($urandom);
            bus.eng_addr  = 6'(i - 26);
        end
        @(posedge clk);
        #1;
        bus.eng_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        ok = (bus.ack == 0) && !bus.err && !bus.busy && !bus.eng_start && !bus.valid;
        check_eq("midrst_ctrl", ok, 1);
        check_eq("midrst_data", {bus.eng_sigma, bus.data, bus.addr, bus.tag}, 0);
        rst = 1'b0;
        rr_ptr = 0;
        check_eq("midrst_noack", ack_q.size() - a0, 0);
        run_job(2, NPoints, 0, 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
